uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit serializer that sits directly downstream of the transmit baud-rate tick generator. It accepts parallel bytes over a valid/ready handshake and shifts them out LSB-first on a single serial line. Bit periods are measured by counting incoming tick pulses, so all baud timing comes from the upstream generator. It produces a standard frame: start bit, data bits, optional parity, then stop bit(s).

## Interface
- DATA_BITS, 8: data bits per frame; legal values are 5 to 8.
- TICKS_PER_BIT, 2: tick pulses per bit period; the generator runs at twice the baud rate.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.
- PARITY_ODD, 0: parity sense, used only when parity is compiled in; 0 selects even, 1 selects odd.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle baud sub-tick pulse from the tick generator.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  serializer can accept a byte.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1, busy=0.
  - A cycle with tx_valid && tx_ready counts as acceptance.
  - On acceptance: latch tx_data into the shift register, clear the bit and tick counters, go to START.
- Bit timing:
  - tick_cnt increments on each tick while not in IDLE.
  - When tick_cnt reaches TICKS_PER_BIT-1 and a tick arrives, the current bit ends and tick_cnt wraps to 0.
  - Ticks that arrive in IDLE are ignored.
- START: tx=0 for one bit period, then go to DATA.
- DATA:
  - tx = shift_reg[0].
  - At each bit end, shift right and increment bit_cnt.
  - After DATA_BITS bits, go to PARITY if it is compiled in, otherwise to STOP.
- PARITY: tx = XOR of the latched data, inverted when PARITY_ODD=1; lasts one bit period.
- STOP:
  - tx=1 for STOP_BITS bit periods.
  - At the final bit end: pulse tx_done and return to IDLE.
- Flow control:
  - tx_ready=0 in every non-IDLE state.
  - tx_valid is ignored while the serializer is busy.
  - tx_data may change freely after acceptance.
- Outputs are registered, with no combinational path from tx_valid or tick to tx.

## Timing
- Reset values: state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, all counters 0.
- Acceptance to output: tx falls to 0 on the clock edge after acceptance; busy rises on the same edge.
- First-bit duration: the start bit begins unaligned to the tick stream. Its duration is between (TICKS_PER_BIT-1) and TICKS_PER_BIT tick periods. All later bits are exactly TICKS_PER_BIT tick periods.
- tx_done and return to IDLE:
  - tx_done is high for exactly one cycle, registered on the edge that returns the FSM to IDLE.
  - tx_ready is high in the same cycle as tx_done.
  - A byte presented in that cycle is accepted back-to-back; the line never drops below one full stop-bit period.
- Simultaneous events: tick and acceptance in the same cycle means the tick is not counted.
- Reset mid-frame: tx returns to 1 immediately (asynchronous) and the FSM goes to IDLE. No tx_done is issued and the partial frame is discarded.
- Widths: tick_cnt is $clog2(TICKS_PER_BIT) bits (minimum 1); bit_cnt is 4 bits.

## Configuration
- UART_TX_PARITY_EN defined:
  - The PARITY state exists.
  - A frame is 1 + DATA_BITS + 1 + STOP_BITS bits.
  - PARITY_ODD selects the parity sense.
- UART_TX_PARITY_EN undefined:
  - The PARITY state and the parity logic are absent.
  - DATA goes directly to STOP.
  - PARITY_ODD is ignored.

## Structure
- Shared package uart_pkg holds:
  - the state encoding typedef (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - the line constants LINE_IDLE=1'b1 and LINE_START=1'b0.
- No sub-module is needed. The top level instantiates the tick generator and feeds its tick output into this block.

## Test plan
All scenarios use TICKS_PER_BIT=2 and a tick every 4 clock cycles unless stated otherwise.
- Send 0x55, no parity, 1 stop bit → tx shows 0,1,0,1,0,1,0,1,0,1. Each bit after the start bit lasts 8 clocks. tx_done pulses once, and tx_ready=0 throughout the frame.
- Send 0xA5 with UART_TX_PARITY_EN and PARITY_ODD=0 → data bits 1,0,1,0,0,1,0,1, parity bit 0, stop bit 1. With PARITY_ODD=1 the parity bit is 1.
- Back-to-back: hold tx_valid high with 0x00 then 0xFF → the second frame's start bit immediately follows a full 8-clock stop bit, with no extra idle gap.
- Send 0x3C with STOP_BITS=2 → the line stays high for 16 clocks before tx_done pulses.
- Assert reset during data bit 3 of 0x0F → tx=1 with no clock edge required, tx_ready=1, and no tx_done. A following 0x81 frame transmits correctly.
- Ticks only, tx_valid=0 for 100 cycles → tx stays 1, busy stays 0, tx_done never pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready byte in, LSB-first frame out, timed by upstream baud ticks.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int TICKS_PER_BIT = 2,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        TICKS_PER_BIT < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_serializer: illegal parameter value");
    end

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign bit_end = tick && (tick_cnt == TICK_LAST);

    // Single registered FSM; a tick in the acceptance cycle is not counted because
    // the counter is only advanced outside IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= LINE_IDLE;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                if (tx_valid && tx_ready) begin
                    shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                    tick_cnt  <= '0;
                    bit_cnt   <= '0;
                    state     <= START;
                    tx        <= LINE_START;
                    tx_ready  <= 1'b0;
                    busy      <= 1'b1;
                end
            end else if (tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
                if (bit_end) begin
                    case (state)
                        START: begin
                            state <= DATA;
                            tx    <= shift_reg[0];
                        end
                        DATA: begin
                            shift_reg <= shift_reg >> 1;
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= PARITY;
                                tx      <= parity_bit;
`else
                                state   <= STOP;
                                tx      <= LINE_IDLE;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                tx      <= shift_reg[1];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: begin
                            state <= STOP;
                            tx    <= LINE_IDLE;
                        end
`endif
                        STOP: begin
                            if (bit_cnt == STOP_LAST) begin
                                bit_cnt  <= '0;
                                state    <= IDLE;
                                tx_done  <= 1'b1;
                                tx_ready <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        default: begin
                            state    <= IDLE;
                            tx       <= LINE_IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: two instances (1 stop/even, 2 stop/odd) checked
// every cycle against a tick-counting frame model, plus table vectors and corner sequences.
module tb_uart_tx_serializer;

    localparam int DATA_BITS = 8;
    localparam int TPB       = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] tx_ready, tx, busy, tx_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_ticks = 1'b0;
    int done_cnt;
    logic [15:0] cap [2];

    bit          m_active [2];
    bit          m_done [2];
    int          m_ticks [2];
    int          m_len [2];
    logic [15:0] m_frame [2];

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] frame0;
        logic [15:0] frame1;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(DATA_BITS), .TICKS_PER_BIT(TPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
    );

    uart_tx_serializer #(.DATA_BITS(DATA_BITS), .TICKS_PER_BIT(TPB), .STOP_BITS(2), .PARITY_ODD(1)) dut_two_stop (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
    );

    // Instance k has k+1 stop bits; instance 1 uses odd parity.
    function automatic void buildFrame(input logic [7:0] d, input int k,
                                       output logic [15:0] bits, output int len);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) bits[1 + i] = d[i];
        len = 1 + DATA_BITS;
`ifdef UART_TX_PARITY_EN
        bits[len] = (($countones(d) % 2) == 1) ^ (k == 1);
        len++;
`endif
        len += k + 1;
    endfunction

    task automatic clearModels();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0;
            m_done[k]   = 1'b0;
            m_ticks[k]  = 0;
        end
    endtask

    // Frame model: the bit on the line is frame[ticks_counted / TPB]; frame ends after TPB*len ticks.
    task automatic modelStep(input int k);
        m_done[k] = 1'b0;
        if (!m_active[k]) begin
            if (tx_valid) begin
                buildFrame(tx_data, k, m_frame[k], m_len[k]);
                m_ticks[k]  = 0;
                m_active[k] = 1'b1;
            end
        end else begin
            if (tick) m_ticks[k]++;
            if (m_ticks[k] == TPB * m_len[k]) begin
                m_active[k] = 1'b0;
                m_done[k]   = 1'b1;
            end
        end
    endtask

    task automatic compare(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %b expected %b", name, k, cyc, act, exp);
        end
    endtask

    task automatic compareInt(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    task automatic checkOutput(input int k);
        logic e_tx;
        e_tx = m_active[k] ? m_frame[k][m_ticks[k] / TPB] : 1'b1;
        compare("tx", k, tx[k], e_tx);
        compare("busy", k, busy[k], m_active[k]);
        compare("tx_ready", k, tx_ready[k], !m_active[k]);
        compare("tx_done", k, tx_done[k], m_done[k]);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput(k);
            if (m_active[k]) cap[k][m_ticks[k] / TPB] = tx[k];
        end
        if (tx_done[0]) done_cnt++;
        cyc++;
        tick = rand_ticks ? ($urandom_range(0, 2) == 0) : ((cyc % 4) == 0);
    endtask

    task automatic waitAccept(input int k);
        int n = 0;
        while (!m_active[k] && n < 50) begin
            stepCycle();
            n++;
        end
        compareInt("accept_timeout", k, int'(m_active[k]), 1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((m_active[0] || m_active[1]) && n < 400) begin
            stepCycle();
            n++;
        end
        compareInt("idle_timeout", 0, int'(m_active[0] || m_active[1]), 0);
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        cap[0] = '1;
        cap[1] = '1;
        done_cnt = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        waitAccept(0);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        waitIdle();
    endtask

    initial begin
        int run, got, n;
`ifdef UART_TX_PARITY_EN
        vecs = '{'{8'h55, 16'hFCAA, 16'hFEAA}, '{8'hA5, 16'hFD4A, 16'hFF4A},
                 '{8'h81, 16'hFD02, 16'hFF02}, '{8'h3C, 16'hFC78, 16'hFE78},
                 '{8'hFF, 16'hFDFE, 16'hFFFE}, '{8'h01, 16'hFE02, 16'hFC02}};
`else
        vecs = '{'{8'h55, 16'hFEAA, 16'hFEAA}, '{8'hA5, 16'hFF4A, 16'hFF4A},
                 '{8'h81, 16'hFF02, 16'hFF02}, '{8'h3C, 16'hFE78, 16'hFE78},
                 '{8'hFF, 16'hFFFE, 16'hFFFE}, '{8'h01, 16'hFE02, 16'hFE02}};
`endif
        reset = 1'b1;
        tick = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        clearModels();
        #1;
        for (int k = 0; k < 2; k++) checkOutput(k);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) checkOutput(k);

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].data);
            compareInt($sformatf("frame_%02h", vecs[v].data), 0, int'(cap[0]), int'(vecs[v].frame0));
            compareInt($sformatf("frame_%02h", vecs[v].data), 1, int'(cap[1]), int'(vecs[v].frame1));
            compareInt("done_pulses", 0, done_cnt, 1);
        end

        // Back-to-back: the gap is one 8-clock stop bit plus the tx_done cycle that accepts the next byte.
        tx_data = 8'h00;
        tx_valid = 1'b1;
        waitAccept(0);
        tx_data = 8'hFF;
        run = 0;
        got = -1;
        n = 0;
        while (got < 0 && n < 200) begin
            stepCycle();
            n++;
            if (tx[0]) run++;
            else begin
                if (run > 0) got = run;
                run = 0;
            end
        end
        compareInt("b2b_high_clocks", 0, got, 9);
        tx_valid = 1'b0;
        waitIdle();

        // Two stop bits: line high for 16 clocks before tx_done (odd parity of 0x3C adds a high bit).
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        waitAccept(1);
        tx_valid = 1'b0;
        run = 0;
        got = -1;
        n = 0;
        while (got < 0 && n < 200) begin
            stepCycle();
            n++;
            if (tx_done[1]) got = run;
            else if (busy[1] && tx[1]) run++;
            else run = 0;
        end
`ifdef UART_TX_PARITY_EN
        compareInt("stop2_high_clocks", 1, got, 24);
`else
        compareInt("stop2_high_clocks", 1, got, 16);
`endif
        waitIdle();

        // Asynchronous reset mid-frame (data bit 3, then data bit 4), then a clean 0x81 frame.
        for (int r = 0; r < 2; r++) begin
            tx_data = 8'h0F;
            tx_valid = 1'b1;
            waitAccept(0);
            tx_valid = 1'b0;
            n = 0;
            while (!(m_active[0] && (m_ticks[0] / TPB) == 4 + r) && n < 100) begin
                stepCycle();
                n++;
            end
            compareInt("reach_bit", 0, m_ticks[0] / TPB, 4 + r);
            #2;
            reset = 1'b1;
            clearModels();
            #1;
            for (int k = 0; k < 2; k++) checkOutput(k);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            done_cnt = 0;
            repeat (20) stepCycle();
            compareInt("no_done_after_reset", 0, done_cnt, 0);
            applyStimulus(8'h81);
            compareInt("frame_after_reset", 0, int'(cap[0]), int'(vecs[2].frame0));
        end

        // Ticks only, no valid: line stays idle.
        tx_valid = 1'b0;
        done_cnt = 0;
        repeat (100) stepCycle();
        compareInt("idle_ticks_done", 0, done_cnt, 0);

        // Randomized traffic and irregular tick stream against the model.
        rand_ticks = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            stepCycle();
        end
        tx_valid = 1'b0;
        waitIdle();
        rand_ticks = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
